// File: rtl/cpu_bus_arbiter.sv
// N-master to 1-slave native memory bus arbiter with burst-long grants and registered arbitration.
// Optional round-robin arbitration when ARB_ROUND_ROBIN_EN is defined; fixed priority (master 0 first) otherwise.
module cpu_bus_arbiter #(
  parameter int N_MST     = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_MST*ADDR_W-1:0]    m_addr,
  input  logic [N_MST*2-1:0]         m_burst,
  input  logic [N_MST-1:0]           m_req,
  input  logic [N_MST-1:0]           m_wrb,
  input  logic [N_MST*DATA_W-1:0]    m_wdata,
  input  logic [N_MST*DATA_W/8-1:0]  m_bstrobe,
  output logic [DATA_W-1:0]          m_rdata,
  output logic [N_MST-1:0]           m_ack,
  output logic [N_MST-1:0]           m_stall,
  output logic [N_MST-1:0]           m_gnt,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [1:0]                 s_burst,
  output logic                       s_req,
  output logic                       s_wrb,
  output logic [DATA_W-1:0]          s_wdata,
  output logic [DATA_W/8-1:0]        s_bstrobe,
  input  logic [DATA_W-1:0]          s_rdata,
  input  logic                       s_ack,
  input  logic                       s_stall
);

  localparam int STRB_W    = DATA_W / 8;
  localparam int BURST_W   = 2;
  localparam int IDX_W     = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam int CNT_W     = $clog2(BURST_LEN);
  localparam int LAST_BEAT = BURST_LEN - 32'sd1;
  localparam int LAST_MST  = N_MST - 32'sd1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [IDX_W-1:0] win_idx_s;
  logic [IDX_W-1:0] next_ptr_s;
  logic [1:0]       win_burst_s;
  logic             any_req_s;
  logic             gnt_req_s;
  logic             burst_multi_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

  assign any_req_s     = |m_req;
  assign gnt_req_s     = m_req[gnt_idx_q];
  assign win_burst_s   = m_burst[int'(win_idx_s)*BURST_W +: BURST_W];
  assign burst_multi_s = (win_burst_s == 2'b01) || (win_burst_s == 2'b10);
  assign next_ptr_s    = (gnt_idx_q == IDX_W'(LAST_MST)) ? IDX_W'(0) : gnt_idx_q + IDX_W'(1);
  assign m_rdata       = s_rdata;

`ifdef ARB_ROUND_ROBIN_EN
  // Winner select: scan downward so the last hit is the first requester at or after rr_ptr.
  always_comb begin
    int cand;
    cand      = 0;
    win_idx_s = IDX_W'(0);
    for (int k = N_MST - 1; k >= 0; k--) begin
      cand      = (int'(rr_ptr_q) + k) % N_MST;
      win_idx_s = m_req[cand] ? IDX_W'(cand) : win_idx_s;
    end
  end
`else
  // Winner select: lowest requesting index wins.
  always_comb begin
    win_idx_s = IDX_W'(0);
    for (int i = N_MST - 1; i >= 0; i--) begin
      win_idx_s = m_req[i] ? IDX_W'(i) : win_idx_s;
    end
  end
`endif

  // State register: FSM state, grant index, beat counter and rotation pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_idx_q  <= IDX_W'(0);
      beat_cnt_q <= CNT_W'(0);
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_q   <= IDX_W'(0);
`endif
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      beat_cnt_q <= beat_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  // Next-state logic: arbitrate in IDLE, count beats and detect end/abort in GRANT.
  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    beat_cnt_d = beat_cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          state_d    = ST_GRANT;
          gnt_idx_d  = win_idx_s;
          beat_cnt_d = burst_multi_s ? CNT_W'(LAST_BEAT) : CNT_W'(0);
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // A request dropped in the same cycle as s_ack is an abort, not a completed beat.
        if (!gnt_req_s || (s_ack && (beat_cnt_q == CNT_W'(0)))) begin
          state_d  = ST_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
          rr_ptr_d = next_ptr_s;
`endif
        end else if (s_ack) begin
          beat_cnt_d = beat_cnt_q - CNT_W'(1);
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: route the granted master to the slave; everyone else requesting is stalled.
  always_comb begin
    s_addr    = '0;
    s_burst   = 2'b00;
    s_req     = 1'b0;
    s_wrb     = 1'b0;
    s_wdata   = '0;
    s_bstrobe = '0;
    m_ack     = '0;
    m_gnt     = '0;
    m_stall   = m_req;
    if (state_q == ST_GRANT) begin
      s_addr             = m_addr[int'(gnt_idx_q)*ADDR_W +: ADDR_W];
      s_burst            = m_burst[int'(gnt_idx_q)*BURST_W +: BURST_W];
      s_req              = gnt_req_s;
      s_wrb              = m_wrb[gnt_idx_q];
      s_wdata            = m_wdata[int'(gnt_idx_q)*DATA_W +: DATA_W];
      s_bstrobe          = m_bstrobe[int'(gnt_idx_q)*STRB_W +: STRB_W];
      m_gnt[gnt_idx_q]   = 1'b1;
      m_ack[gnt_idx_q]   = gnt_req_s & s_ack;
      m_stall[gnt_idx_q] = gnt_req_s & s_stall;
    end else begin
      m_gnt = '0;
    end
  end

  logic unused_s;
  assign unused_s = ^next_ptr_s;

endmodule
